// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit feeding the HI/LO write port.
// Shift-add multiply and restoring divide on magnitudes, sign fix-up, then a one-cycle write bundle.
module muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              cancel,
  output logic              busy,
  output logic              done,
  output logic              hi_we,
  output logic              lo_we,
  output logic [DATA_W-1:0] wd_hi,
  output logic [DATA_W-1:0] wd_lo
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_WRITE
  } state_t;

  state_t state_q, state_d;

  // Multiply: {upper accumulator, multiplier shifting out}. Divide: low half holds dividend/quotient.
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [DATA_W:0]     rem_q, rem_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                is_div_q, is_div_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                dbz_q, dbz_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                hi_we_q, hi_we_d;
  logic                lo_we_q, lo_we_d;
  logic [DATA_W-1:0]   wd_hi_q, wd_hi_d;
  logic [DATA_W-1:0]   wd_lo_q, wd_lo_d;

  logic                op_mul, op_div, op_signed, op_mthi, op_mtlo;
  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;

  assign op_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign op_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign op_mthi   = (op == OP_MTHI);
  assign op_mtlo   = (op == OP_MTLO);

  assign a_neg = op_signed & src_a[DATA_W-1];
  assign b_neg = op_signed & src_b[DATA_W-1];
  assign a_mag = a_neg ? (-src_a) : src_a;
  assign b_mag = b_neg ? (-src_b) : src_b;

  // One iteration of each algorithm, evaluated every cycle and used only in CALC.
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W+1:0] div_diff;
  logic              div_ge;

  assign mul_sum  = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign div_diff = {rem_q, prod_q[DATA_W-1]} - {2'b00, opnd_q};
  assign div_ge   = ~div_diff[DATA_W+1];

  logic [2*DATA_W-1:0] fix_prod;
  logic [DATA_W-1:0]   fix_quo, fix_rem;

  // A zero divisor leaves the quotient all ones and the remainder equal to the dividend.
  assign fix_prod = neg_res_q ? (-prod_q) : prod_q;
  assign fix_quo  = (neg_res_q && !dbz_q) ? (-prod_q[DATA_W-1:0]) : prod_q[DATA_W-1:0];
  assign fix_rem  = neg_rem_q ? (-rem_q[DATA_W-1:0]) : rem_q[DATA_W-1:0];

  always_comb begin
    state_d   = state_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_we_d   = 1'b0;
    lo_we_d   = 1'b0;
    wd_hi_d   = wd_hi_q;
    wd_lo_d   = wd_lo_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start && !cancel) begin
          if (op_mul || op_div) begin
            state_d   = S_CALC;
            busy_d    = 1'b1;
            cnt_d     = '0;
            is_div_d  = op_div;
            prod_d    = {{DATA_W{1'b0}}, (op_div ? a_mag : b_mag)};
            opnd_d    = op_div ? b_mag : a_mag;
            rem_d     = '0;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            dbz_d     = (src_b == '0);
          end else if (op_mthi || op_mtlo) begin
            state_d = S_WRITE;
            busy_d  = 1'b1;
            done_d  = 1'b1;
            hi_we_d = op_mthi;
            lo_we_d = op_mtlo;
            if (op_mthi) begin
              wd_hi_d = src_a;
            end else begin
              wd_lo_d = src_a;
            end
          end
        end
      end

      S_CALC: begin
        if (cancel) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          if (is_div_q) begin
            prod_d = {prod_q[2*DATA_W-1:DATA_W], prod_q[DATA_W-2:0], div_ge};
            rem_d  = div_ge ? div_diff[DATA_W:0] : {rem_q[DATA_W-1:0], prod_q[DATA_W-1]};
          end else begin
            prod_d = {mul_sum, prod_q[DATA_W-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        if (cancel) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = S_WRITE;
          done_d  = 1'b1;
          hi_we_d = 1'b1;
          lo_we_d = 1'b1;
          wd_hi_d = is_div_q ? fix_rem : fix_prod[2*DATA_W-1:DATA_W];
          wd_lo_d = is_div_q ? fix_quo : fix_prod[DATA_W-1:0];
        end
      end

      S_WRITE: begin
        // The bundle is already on the outputs, so a cancel here cannot retract it.
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      prod_q    <= '0;
      rem_q     <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_we_q   <= 1'b0;
      lo_we_q   <= 1'b0;
      wd_hi_q   <= '0;
      wd_lo_q   <= '0;
    end else begin
      state_q   <= state_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_we_q   <= hi_we_d;
      lo_we_q   <= lo_we_d;
      wd_hi_q   <= wd_hi_d;
      wd_lo_q   <= wd_lo_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi_we = hi_we_q;
  assign lo_we = lo_we_q;
  assign wd_hi = wd_hi_q;
  assign wd_lo = wd_lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expectations queued at issue, popped when done pulses.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        cancel = 1'b0;
  logic        busy, done, hi_we, lo_we;
  logic [31:0] wd_hi, wd_lo;

  muldiv_unit #(.DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .cancel(cancel),
    .busy(busy), .done(done), .hi_we(hi_we), .lo_we(lo_we),
    .wd_hi(wd_hi), .wd_lo(wd_lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        hw;
    logic        lw;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  logic [2:0]  v_op [6] = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd3, 3'd2};
  logic [31:0] v_a  [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000};
  logic [31:0] v_b  [6] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF};
  logic [31:0] v_hi [6] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'd7, 32'h0};
  logic [31:0] v_lo [6] = '{32'hFFFFFFF1, 32'h1, 32'h1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};

  // Reference model written from the arithmetic definition, not the iteration.
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [31:0] sa, sb;
    logic signed [63:0] pa, pb, ps;
    logic [63:0] pu;
    sa = a; sb = b; pa = sa; pb = sb;
    e.hw = 1'b1; e.lw = 1'b1; e.lat = 34; e.hi = '0; e.lo = '0;
    case (o)
      3'd0: begin ps = pa * pb; e.hi = ps[63:32]; e.lo = ps[31:0]; end
      3'd1: begin pu = {32'b0, a} * {32'b0, b}; e.hi = pu[63:32]; e.lo = pu[31:0]; end
      3'd2: begin
        if (b == 0) begin e.lo = 32'hFFFFFFFF; e.hi = a; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin e.lo = a; e.hi = 0; end
        else begin e.lo = sa / sb; e.hi = sa % sb; end
      end
      default: begin
        if (b == 0) begin e.lo = 32'hFFFFFFFF; e.hi = a; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
    endcase
    return e;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic push, input exp_t e);
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns the cycle (1-based after acceptance) in which done is seen, or 0 on timeout.
  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    checks++; if ({busy, done, hi_we, lo_we} !== 4'b0) begin failures++;
      $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, hi_we, lo_we}); end
    checks++; if ({wd_hi, wd_lo} !== 64'h0) begin failures++;
      $display("FAIL reset_data: got %h expected 0", {wd_hi, wd_lo}); end
    @(posedge clk); #1;
    checks++; if ({busy, done, hi_we, lo_we} !== 4'b0) begin failures++;
      $display("FAIL reset_hold: got %b expected 0000", {busy, done, hi_we, lo_we}); end
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic test_vectors;
    exp_t e;
    int c;
    for (int i = 0; i < 6; i++) begin
      e.hw = 1'b1; e.lw = 1'b1; e.hi = v_hi[i]; e.lo = v_lo[i]; e.lat = 34;
      issue(v_op[i], v_a[i], v_b[i], 1'b1, e);
      if (i == 0) begin
        checks++; if (busy !== 1'b1) begin failures++;
          $display("FAIL vec_busy_c1: got %b expected 1", busy); end
      end
      wait_done(40, c);
      e = exp_q.pop_front();
      $display("txn vec%0d op=%0d a=%h b=%h hi=%h lo=%h cyc=%0d", i, v_op[i], v_a[i], v_b[i], wd_hi, wd_lo, c);
      checks++; if (c !== e.lat) begin failures++; $display("FAIL vec%0d_lat: got %0d expected %0d", i, c, e.lat); end
      checks++; if ({hi_we, lo_we} !== {e.hw, e.lw}) begin failures++;
        $display("FAIL vec%0d_we: got %b expected %b", i, {hi_we, lo_we}, {e.hw, e.lw}); end
      checks++; if (wd_hi !== e.hi) begin failures++; $display("FAIL vec%0d_hi: got %h expected %h", i, wd_hi, e.hi); end
      checks++; if (wd_lo !== e.lo) begin failures++; $display("FAIL vec%0d_lo: got %h expected %h", i, wd_lo, e.lo); end
      if (i == 0) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL vec_busy_done: got %b expected 1", busy); end
        @(negedge clk);
        checks++; if ({busy, done, hi_we, lo_we} !== 4'b0) begin failures++;
          $display("FAIL vec_after_done: got %b expected 0000", {busy, done, hi_we, lo_we}); end
      end
    end
  endtask

  task automatic test_mt;
    exp_t e;
    int c;
    e.hw = 1'b1; e.lw = 1'b0; e.hi = 32'h1234; e.lo = '0; e.lat = 1;
    issue(3'd4, 32'h1234, 32'hFFFF, 1'b1, e);
    wait_done(5, c);
    e = exp_q.pop_front();
    $display("txn mthi a=1234 hi_we=%b lo_we=%b hi=%h cyc=%0d", hi_we, lo_we, wd_hi, c);
    checks++; if (c !== e.lat) begin failures++; $display("FAIL mthi_lat: got %0d expected %0d", c, e.lat); end
    checks++; if ({hi_we, lo_we} !== {e.hw, e.lw}) begin failures++;
      $display("FAIL mthi_we: got %b expected %b", {hi_we, lo_we}, {e.hw, e.lw}); end
    checks++; if (wd_hi !== e.hi) begin failures++; $display("FAIL mthi_hi: got %h expected %h", wd_hi, e.hi); end
    e.hw = 1'b0; e.lw = 1'b1; e.hi = 32'h1234; e.lo = 32'hABCD; e.lat = 1;
    issue(3'd5, 32'hABCD, 32'h0, 1'b1, e);
    wait_done(5, c);
    e = exp_q.pop_front();
    $display("txn mtlo a=abcd hi_we=%b lo_we=%b lo=%h cyc=%0d", hi_we, lo_we, wd_lo, c);
    checks++; if (c !== e.lat) begin failures++; $display("FAIL mtlo_lat: got %0d expected %0d", c, e.lat); end
    checks++; if ({hi_we, lo_we} !== {e.hw, e.lw}) begin failures++;
      $display("FAIL mtlo_we: got %b expected %b", {hi_we, lo_we}, {e.hw, e.lw}); end
    checks++; if ({wd_hi, wd_lo} !== {e.hi, e.lo}) begin failures++;
      $display("FAIL mtlo_data: got %h expected %h", {wd_hi, wd_lo}, {e.hi, e.lo}); end
  endtask

  task automatic test_random;
    exp_t e;
    int c;
    logic [2:0] o;
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = (i == 2) ? 32'h0 : ((i == 4) ? 32'($urandom_range(1, 20)) : $urandom);
      e = model(o, a, b);
      issue(o, a, b, 1'b1, e);
      wait_done(40, c);
      e = exp_q.pop_front();
      $display("txn rnd%0d op=%0d a=%h b=%h hi=%h lo=%h cyc=%0d", i, o, a, b, wd_hi, wd_lo, c);
      checks++; if (c !== e.lat) begin failures++; $display("FAIL rnd%0d_lat: got %0d expected %0d", i, c, e.lat); end
      checks++; if ({hi_we, lo_we, wd_hi, wd_lo} !== {e.hw, e.lw, e.hi, e.lo}) begin failures++;
        $display("FAIL rnd%0d_result: got we=%b %h_%h expected we=%b %h_%h", i,
                 {hi_we, lo_we}, wd_hi, wd_lo, {e.hw, e.lw}, e.hi, e.lo); end
    end
  endtask

  task automatic test_busy_ignore;
    exp_t e;
    int c;
    e.hw = 1'b1; e.lw = 1'b1; e.hi = 32'd2; e.lo = 32'd14; e.lat = 29;
    issue(3'd3, 32'd100, 32'd7, 1'b1, e);
    repeat (4) @(posedge clk);
    #1; start = 1'b1; op = 3'd4; src_a = 32'hDEAD;
    @(posedge clk); #1; start = 1'b0;
    wait_done(40, c);
    e = exp_q.pop_front();
    $display("txn busy_ignore hi=%h lo=%h cyc=%0d", wd_hi, wd_lo, c + 5);
    checks++; if (c !== e.lat) begin failures++; $display("FAIL busy_lat: got %0d expected %0d", c, e.lat); end
    checks++; if ({wd_hi, wd_lo} !== {e.hi, e.lo}) begin failures++;
      $display("FAIL busy_result: got %h expected %h", {wd_hi, wd_lo}, {e.hi, e.lo}); end
    wait_done(10, c);
    checks++; if (c !== 0) begin failures++; $display("FAIL busy_extra_write: got done at %0d expected none", c); end
    checks++; if (wd_hi !== 32'd2) begin failures++; $display("FAIL busy_hi_kept: got %h expected 2", wd_hi); end
  endtask

  task automatic test_cancel;
    exp_t e;
    int c;
    issue(3'd0, 32'd3, 32'd4, 1'b0, e);
    repeat (9) @(posedge clk);
    #1; cancel = 1'b1;
    @(posedge clk); #1; cancel = 1'b0;
    checks++; if ({busy, done, hi_we, lo_we} !== 4'b0) begin failures++;
      $display("FAIL cancel_c11: got %b expected 0000", {busy, done, hi_we, lo_we}); end
    e.hw = 1'b1; e.lw = 1'b1; e.hi = 32'h1; e.lo = 32'h0; e.lat = 34;
    start = 1'b1; op = 3'd1; src_a = 32'h10000; src_b = 32'h10000;
    exp_q.push_back(e);
    @(posedge clk); #1; start = 1'b0;
    wait_done(40, c);
    e = exp_q.pop_front();
    $display("txn cancel_restart hi=%h lo=%h cyc=%0d", wd_hi, wd_lo, c + 11);
    checks++; if (c + 11 !== 45) begin failures++; $display("FAIL cancel_restart_cycle: got %0d expected 45", c + 11); end
    checks++; if ({wd_hi, wd_lo} !== {e.hi, e.lo}) begin failures++;
      $display("FAIL cancel_restart_result: got %h expected %h", {wd_hi, wd_lo}, {e.hi, e.lo}); end
  endtask

  task automatic test_cancel_start;
    int c;
    @(posedge clk); #1;
    start = 1'b1; cancel = 1'b1; op = 3'd0; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cancel_start_busy: got %b expected 0", busy); end
    wait_done(40, c);
    checks++; if (c !== 0) begin failures++; $display("FAIL cancel_start_write: got done at %0d expected none", c); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int c;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd1; src_a = 32'h0000FFFF; src_b = 32'h00010001;
    exp_q.push_back(model(3'd1, 32'h0000FFFF, 32'h00010001));
    @(posedge clk); #1;
    op = 3'd2; src_a = 32'h80000000; src_b = 32'd3;
    exp_q.push_back(model(3'd2, 32'h80000000, 32'd3));
    wait_done(40, c);
    e = exp_q.pop_front();
    $display("txn b2b_first hi=%h lo=%h cyc=%0d", wd_hi, wd_lo, c);
    checks++; if (c !== 34) begin failures++; $display("FAIL b2b_first_lat: got %0d expected 34", c); end
    checks++; if ({wd_hi, wd_lo} !== {e.hi, e.lo}) begin failures++;
      $display("FAIL b2b_first_result: got %h expected %h", {wd_hi, wd_lo}, {e.hi, e.lo}); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_gap_busy: got %b expected 0", busy); end
    @(posedge clk); #1; start = 1'b0;
    wait_done(40, c);
    e = exp_q.pop_front();
    $display("txn b2b_second hi=%h lo=%h cyc=%0d", wd_hi, wd_lo, c + 35);
    checks++; if (c + 35 !== 69) begin failures++; $display("FAIL b2b_second_cycle: got %0d expected 69", c + 35); end
    checks++; if ({wd_hi, wd_lo} !== {e.hi, e.lo}) begin failures++;
      $display("FAIL b2b_second_result: got %h expected %h", {wd_hi, wd_lo}, {e.hi, e.lo}); end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int c;
    issue(3'd0, 32'h7, 32'h9, 1'b0, e);
    repeat (19) @(posedge clk);
    #2; resetn = 1'b0;
    #1;
    checks++; if ({busy, done, hi_we, lo_we} !== 4'b0) begin failures++;
      $display("FAIL midreset_ctrl: got %b expected 0000", {busy, done, hi_we, lo_we}); end
    checks++; if ({wd_hi, wd_lo} !== 64'h0) begin failures++;
      $display("FAIL midreset_data: got %h expected 0", {wd_hi, wd_lo}); end
    @(negedge clk); resetn = 1'b1;
    wait_done(45, c);
    checks++; if (c !== 0) begin failures++; $display("FAIL midreset_write: got done at %0d expected none", c); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_mt();
    test_random();
    test_busy_ignore();
    test_cancel();
    test_cancel_start();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
